// File: rtl/bin2dec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2dec_seq_pkg
// Description : Shared constants and FSM encoding for the sequential
//               binary-to-BCD converter.
// Revision    : 1.0
// ============================================================================
package bin2dec_seq_pkg;

    localparam int BITS_DEF      = 14;
    localparam int DIGITS_DEF    = 4;
    localparam int MAX_VALUE_DEF = 9999;
    localparam int LATENCY       = DIGITS_DEF * (BITS_DEF + 1);

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [4:0] DIVISOR   = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bin2dec_seq_div10_step.sv
`default_nettype none
// ============================================================================
// Module      : div10_step
// Description : One restoring-division-by-10 stage: shifts in one dividend
//               bit and yields the new remainder and quotient bit.
// Revision    : 1.0
// ============================================================================
module div10_step
    import bin2dec_seq_pkg::*;
(
    input  logic [3:0] i_rem,
    input  logic       i_bit,
    output logic [3:0] o_rem,
    output logic       o_q
);

    logic [4:0] w_t;
    logic [3:0] w_diff;

    assign w_t    = {i_rem, i_bit};
    // t < 20 whenever the quotient bit is set, so the difference fits in 4 bits
    assign w_diff = 4'(w_t - DIVISOR);
    assign o_q    = (w_t >= DIVISOR);
    assign o_rem  = o_q ? w_diff : w_t[3:0];

endmodule
`default_nettype wire

// File: rtl/bin2dec_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2dec_seq
// Description : Sequential binary-to-BCD converter, one quotient bit per clock.
// Revision    : 1.0
// ============================================================================
module bin2dec_seq
    import bin2dec_seq_pkg::*;
#(
    parameter int BITS      = BITS_DEF,
    parameter int DIGITS    = DIGITS_DEF,
    parameter int MAX_VALUE = MAX_VALUE_DEF
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BITS-1:0]       number,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int BW = $clog2(BITS);
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                r_state;
    state_t                w_next;
    logic [BITS-1:0]       r_dividend;
    logic [BITS-1:0]       r_quo;
    logic [3:0]            r_rem;
    logic [BW-1:0]         r_bit;
    logic [KW-1:0]         r_k;
    logic [4*DIGITS-1:0]   r_acc;
    logic [4*DIGITS-1:0]   r_digits;
    logic                  r_err;

    logic [3:0]            w_rem_next;
    logic                  w_qbit;
    logic                  w_overflow;
    logic                  w_last_bit;
    logic                  w_last_digit;
    logic [4*DIGITS-1:0]   w_acc_final;

    div10_step u_step (
        .i_rem (r_rem),
        .i_bit (r_dividend[r_bit]),
        .o_rem (w_rem_next),
        .o_q   (w_qbit)
    );

    assign w_overflow   = (number > BITS'(MAX_VALUE));
    assign w_last_bit   = (r_bit == '0);
    assign w_last_digit = (r_k == KW'(DIGITS - 1));

    // Digits collect here and reach the output only on entry to DONE
    always_comb begin
        w_acc_final = r_acc;
        w_acc_final[{r_k, 2'b00} +: 4] = r_rem;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_overflow ? S_DONE : S_DIV;
            S_DIV:   if (w_last_bit) w_next = S_STORE;
            S_STORE: w_next = w_last_digit ? S_DONE : S_DIV;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_dividend <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_bit      <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_digits   <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_overflow) begin
                            r_err    <= 1'b1;
                            r_digits <= {DIGITS{BCD_BLANK}};
                        end else begin
                            r_dividend <= number;
                            r_rem      <= '0;
                            r_quo      <= '0;
                            r_bit      <= BW'(BITS - 1);
                            r_k        <= '0;
                        end
                    end
                end
                S_DIV: begin
                    r_rem        <= w_rem_next;
                    r_quo[r_bit] <= w_qbit;
                    if (!w_last_bit) begin
                        r_bit <= r_bit - 1'b1;
                    end
                end
                S_STORE: begin
                    r_acc      <= w_acc_final;
                    r_dividend <= r_quo;
                    r_rem      <= '0;
                    r_quo      <= '0;
                    r_bit      <= BW'(BITS - 1);
                    if (w_last_digit) begin
                        r_digits <= w_acc_final;
                        r_err    <= 1'b0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digits = r_digits;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bin2dec_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2dec_seq
// Description : Scoreboard bench for bin2dec_seq with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_bin2dec_seq;
    import bin2dec_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] number;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] digits;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] hold_d = '0;
    logic        hold_e = 1'b0;

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          c;
    } exp_t;
    exp_t q[$];

    bin2dec_seq dut (
        .mclk   (clk),
        .rst    (rst),
        .start  (start),
        .number (number),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .digits (digits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [15:0] ref_bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        r = '0;
        if (n > 9999) return 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every done, otherwise verifies the outputs hold
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("digits", 32'(digits), 32'(e.d));
                    chk("err", 32'(err), 32'(e.e));
                    chk("done_cycle", 32'(cyc), 32'(e.c));
                    hold_d = e.d;
                    hold_e = e.e;
                end
            end else begin
                chk("digits_hold", 32'(digits), 32'(hold_d));
                chk("err_hold", 32'(err), 32'(hold_e));
            end
        end
    end

    task automatic issue(input logic [13:0] n, input logic [15:0] ed, input logic ee,
                         input bit push, output int acc);
        exp_t e;
        int   g;
        g = 0;
        @(negedge clk);
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
        start  = 1'b1;
        number = n;
        acc    = cyc + 1;
        if (push) begin
            e.d = ed;
            e.e = ee;
            e.c = acc + (ee ? 0 : LATENCY);
            q.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        number = 14'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("done_arrived", 32'(q.size()), 32'd0);
    endtask

    task automatic run(input logic [13:0] n, input logic [15:0] ed, input logic ee);
        int acc;
        issue(n, ed, ee, 1'b1, acc);
        drain();
    endtask

    int   acc;
    exp_t e2;
    int   vec[8] = '{9998, 9999, 10000, 16383, 1, 10, 100, 1000};

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        number = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run(14'd1682, 16'h1682, 1'b0);
        run(14'd0, 16'h0000, 1'b0);
        run(14'd9999, 16'h9999, 1'b0);
        run(14'd10000, 16'hFFFF, 1'b1);
        run(14'd42, 16'h0042, 1'b0);

        // start held high through the whole first conversion
        issue(14'd1682, 16'h1682, 1'b0, 1'b1, acc);
        start  = 1'b1;
        number = 14'd5;
        e2.d = 16'h0005;
        e2.e = 1'b0;
        e2.c = acc + 62 + LATENCY;
        q.push_back(e2);
        while (cyc < acc + 62) @(negedge clk);
        start = 1'b0;
        drain();

        // reset in the middle of a conversion
        issue(14'd9, 16'h0009, 1'b0, 1'b0, acc);
        while (cyc < acc + 30) @(negedge clk);
        rst    = 1'b1;
        hold_d = '0;
        hold_e = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_digits", 32'(digits), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        run(14'd7, 16'h0007, 1'b0);

        foreach (vec[i]) run(14'(vec[i]), ref_bcd(vec[i]), vec[i] > 9999);
        for (int i = 0; i < 8; i++) begin
            int n;
            n = int'($urandom_range(0, 16383));
            run(14'(n), ref_bcd(n), n > 9999);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
